// File: rtl/drum_env.sv
// drum_env: percussive attack/decay envelope applied to an offset-binary sample stream.
//
// A rising edge on trigger restarts the attack phase from the current envelope
// level. Attack ramps env up by ATTACK_STEP per accepted sample until it reaches
// 255. Decay then lowers env by DECAY_STEP once every DECAY_DIV accepted samples
// until it reaches 0, and the block returns to idle. Every valid sample is scaled
// by the envelope and registered out with one cycle of latency.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous active-high reset
//   trigger      : strike request (level); only its rising edge acts
//   sample_in    : 8-bit offset-binary input sample (0x80 = zero)
//   sample_valid : single-cycle strobe qualifying sample_in
//   dout         : 8-bit offset-binary enveloped sample
//   dout_valid   : single-cycle strobe qualifying dout (one cycle after sample_valid)
//   env          : current envelope level (0 = silent, 255 = full)
//   busy         : high whenever the envelope state is not IDLE
module drum_env #(
  parameter logic [7:0]  ATTACK_STEP = 8'd32,
  parameter logic [15:0] DECAY_DIV   = 16'd64,
  parameter logic [7:0]  DECAY_STEP  = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [7:0] env,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DECAY  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_trig_d;
  logic [7:0]  r_env;
  logic [7:0]  w_env_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_edge;
  logic [7:0]  r_dout_p1;
  logic        r_vld_p1;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] dif;
    dif = {1'b0, a} - {1'b0, b};
    // a borrow out of bit 8 means the result went below zero
    return dif[8] ? 8'h00 : dif[7:0];
  endfunction

  // Offset-binary sample times envelope: the arithmetic shift floors toward
  // minus infinity, so the result stays within 0x00..0xFE and needs no clamp.
  function automatic logic [7:0] env_scale(input logic [7:0] smp, input logic [7:0] lvl);
    logic signed [8:0]  s9;
    logic signed [16:0] s17;
    logic signed [16:0] e17;
    s9  = $signed({1'b0, smp}) - 9'sd128;
    s17 = {{8{s9[8]}}, s9};
    e17 = $signed({9'b0, lvl});
    return 8'((s17 * e17) >>> 8) + 8'h80;
  endfunction

  assign w_edge = trigger & ~r_trig_d;

  // State register together with the envelope and decay counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_env    <= 8'd0;
      r_cnt    <= 16'd0;
      r_trig_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_env    <= w_env_nxt;
      r_cnt    <= w_cnt_nxt;
      r_trig_d <= trigger;
    end
  end

  // Next-state logic; a trigger edge wins over any sample-driven transition
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_cnt_nxt   = r_cnt;
    if (w_edge) begin
      w_state_nxt = ST_ATTACK;
      w_cnt_nxt   = 16'd0;
    end else if (sample_valid) begin
      case (r_state)
        ST_ATTACK: begin
          w_env_nxt = sat_add(r_env, ATTACK_STEP);
          if (w_env_nxt == 8'hFF) begin
            w_state_nxt = ST_DECAY;
            w_cnt_nxt   = 16'd0;
          end
        end
        ST_DECAY: begin
          if (r_cnt == DECAY_DIV - 16'd1) begin
            w_cnt_nxt = 16'd0;
            w_env_nxt = sat_sub(r_env, DECAY_STEP);
            if (w_env_nxt == 8'd0) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_env_nxt   = 8'd0;
          w_cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  // Stage p0 -> p1: scale the sample by the pre-update envelope
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_p1 <= 8'h80;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= sample_valid;
      if (sample_valid) begin
        r_dout_p1 <= env_scale(sample_in, r_env);
      end
    end
  end

  assign dout       = r_dout_p1;
  assign dout_valid = r_vld_p1;
  assign env        = r_env;

endmodule

// File: doc/drum_env.md
DRUM_ENV -- requirements
Module: drum_env

Interface
REQ-001 SHALL have parameter ATTACK_STEP, default 8'd32, envelope increment applied per accepted sample in ATTACK (legal 1..255).
REQ-002 SHALL have parameter DECAY_DIV, default 16'd64, number of accepted samples per decay step (legal 1..65535).
REQ-003 SHALL have parameter DECAY_STEP, default 8'd1, envelope decrement per decay step (legal 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port trigger, input, 1, strike request, synchronous to clk, level; only its rising edge acts.
REQ-007 SHALL have port sample_in, input, 8, unsigned offset-binary oscillator/noise sample, 0x80 = zero.
REQ-008 SHALL have port sample_valid, input, 1, single-cycle strobe qualifying sample_in.
REQ-009 SHALL have port dout, output, 8, enveloped sample, offset-binary.
REQ-010 SHALL have port dout_valid, output, 1, single-cycle strobe qualifying dout.
REQ-011 SHALL have port env, output, 8, current envelope level, 0 = silent, 255 = full.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ATTACK, DECAY; busy = (state != IDLE), combinational from the state register.
REQ-014 SHALL register trigger into trig_d each cycle; edge = trigger & ~trig_d.
REQ-015 On edge, from any state, SHALL set state to ATTACK and clear the decay counter; env SHALL NOT change in that cycle, so a retrigger continues from the current level.
REQ-016 env and the decay counter SHALL update only in cycles where sample_valid = 1 and edge = 0.
REQ-017 In ATTACK, on each accepted sample: env <= min(env + ATTACK_STEP, 255), computed at 9 bits; when the result is 255, state <= DECAY and decay counter <= 0 in the same cycle.
REQ-018 In DECAY, on each accepted sample: if counter == DECAY_DIV-1, counter <= 0 and env <= max(env - DECAY_STEP, 0); otherwise counter <= counter + 1.
REQ-019 When a DECAY decrement yields env = 0, state SHALL become IDLE in the same cycle.
REQ-020 In IDLE, env SHALL hold 0 and the counter SHALL hold 0.
REQ-021 On every cycle with sample_valid = 1, in any state and regardless of edge, the block SHALL compute, using env as it stands before that cycle's update: s = sample_in - 128 (9-bit signed); p = s * env (17-bit signed, env zero-extended); dout <= (p >>> 8) + 128, truncated to 8 bits.
REQ-022 The result of REQ-021 SHALL lie in 0x00..0xFE; no saturation logic is required.
REQ-023 dout_valid SHALL be high exactly one cycle after each sample_valid cycle (latency 1) and low otherwise; back-to-back sample_valid SHALL yield back-to-back dout_valid.
REQ-024 dout SHALL hold its last value when dout_valid = 0.
REQ-025 An edge coinciding with the ATTACK-to-DECAY transition or the DECAY-to-IDLE transition SHALL take priority: next state ATTACK, env unchanged.

Reset
REQ-026 While reset = 1 at a clock edge: state <= IDLE, env <= 0, counter <= 0, dout <= 0x80, dout_valid <= 0, trig_d <= 0; all other inputs ignored.
REQ-027 Reset SHALL override any mid-attack or mid-decay operation; trigger held high when reset releases SHALL count as one edge.

Verification
REQ-028 Reset, then sample_valid every 4 cycles with sample_in = 0xFF, no trigger -> dout = 0x80 on every dout_valid, env = 0, busy = 0.
REQ-029 Defaults; trigger pulse, then 8 samples -> env sequence 32,64,...,224,255, state DECAY after the 8th, busy = 1 throughout.
REQ-030 DECAY_DIV = 2, DECAY_STEP = 1; after reaching env = 255, feed 510 samples -> env decrements every 2nd sample and reaches 0 on the 510th; state IDLE, busy = 0 on the next cycle.
REQ-031 env = 255 (forced via attack); sample_in 0xFF -> dout 0xFE; 0x00 -> 0x00; 0x80 -> 0x80; env = 128, sample_in 0xC0 -> dout 0xA0.
REQ-032 Retrigger at env = 100 in DECAY with sample_valid in the same cycle -> dout computed with env 100, env stays 100, state ATTACK; the next sample gives env 132.
REQ-033 Assert reset mid-ATTACK at env = 96 -> next cycle env = 0, state IDLE, dout = 0x80, dout_valid = 0.
